// File: rtl/johnson_counter_gen.sv
// rtl/johnson_counter_gen.sv - N-bit Johnson counter with up/down, validated load, phase index, wrap/illegal pulses
// Optional feature macro: JOHNSON_GRAY_OUT_EN (adds registered Gray-coded phase output g)
module johnson_counter_gen #(
    parameter int N       = 4,
    parameter int PHASE_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [N-1:0]       load_val,
    output logic [N-1:0]       j,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap,
    output logic               illegal
`ifdef JOHNSON_GRAY_OUT_EN
    ,
    output logic [PHASE_W-1:0] g
`endif
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * N - 1);

    logic [N-1:0]       j_q, j_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               wrap_q, wrap_d;
    logic               illegal_q, illegal_d;
    logic               load_legal;
    int                 trans_cnt;
    int                 pop_cnt;

    // Classify load_val: legal Johnson codes have at most one adjacent-bit transition
    always_comb begin
        trans_cnt = 0;
        pop_cnt   = 0;
        for (int i = 0; i < N - 1; i++) begin
            if (load_val[i] != load_val[i+1]) begin
                trans_cnt = trans_cnt + 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (load_val[i]) begin
                pop_cnt = pop_cnt + 1;
            end
        end
        load_legal = (trans_cnt <= 1);
    end

    // Next-state selection: load beats en beats hold; wrap/illegal default low
    always_comb begin
        j_d       = j_q;
        phase_d   = phase_q;
        wrap_d    = 1'b0;
        illegal_d = 1'b0;
        if (load) begin
            if (load_legal) begin
                j_d = load_val;
                // Codes with MSB set lie in the back half of the up sequence
                if (load_val[N-1]) begin
                    phase_d = PHASE_W'(2 * N - pop_cnt);
                end else begin
                    phase_d = PHASE_W'(pop_cnt);
                end
            end else begin
                j_d       = '0;
                phase_d   = '0;
                illegal_d = 1'b1;
            end
        end else if (en) begin
            if (dir) begin
                j_d = {j_q[N-2:0], ~j_q[N-1]};
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end else begin
                j_d = {~j_q[0], j_q[N-1:1]};
                if (phase_q == '0) begin
                    phase_d = PHASE_LAST;
                    wrap_d  = 1'b1;
                end else begin
                    phase_d = phase_q - PHASE_W'(1);
                end
            end
        end
    end

    // Counter state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_q       <= '0;
            phase_q   <= '0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            j_q       <= j_d;
            phase_q   <= phase_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
        end
    end

    assign j       = j_q;
    assign phase   = phase_q;
    assign wrap    = wrap_q;
    assign illegal = illegal_q;

`ifdef JOHNSON_GRAY_OUT_EN
    logic [PHASE_W-1:0] g_q, g_d;

    // Reference Gray code of the next phase, so g lines up with j
    always_comb begin
        g_d = phase_d ^ (phase_d >> 1);
    end

    // Gray reference register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q <= '0;
        end else begin
            g_q <= g_d;
        end
    end

    assign g = g_q;
`endif

endmodule
